decode_stage_pipe: RTL

//  Parametrised ID stage with its own ID/EX pipeline register. Decodes one fixed 32-bit instruction per cycle.

---
 rtl/decode_stage_pipe.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: ID stage with ID/EX register, regfile, condition check and RAW hazard detection (WB_BYPASS_EN enables same-cycle WB read bypass)
module decode_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int NREG = 16,
  localparam int RA_W = NREG > 1 ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  input  logic [31:0]       pc_in,
  input  logic [3:0]        status,
  input  logic              flush,
  input  logic              exe_wb_en,
  input  logic [RA_W-1:0]   exe_dest,
  input  logic              mem_wb_en,
  input  logic [RA_W-1:0]   mem_dest,
  input  logic              wb_we,
  input  logic [RA_W-1:0]   wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              b,
  output logic              s,
  output logic [3:0]        exe_cmd,
  output logic              imm,
  output logic [11:0]       shift_operand,
  output logic [23:0]       signed_imm24,
  output logic [RA_W-1:0]   dest,
  output logic [DATA_W-1:0] val_rn,
  output logic [DATA_W-1:0] val_rm,
  output logic [31:0]       pc_out
);
  logic [DATA_W-1:0] regs [2**RA_W];
  logic [1:0] mode;
  logic [3:0] opcode, cond;
  logic i_bit, s_bit, n, z, c, v, str, src1_used, src2_used, hazard, advance, cond_ok;
  logic [RA_W-1:0] rn, rd, rm, src2;
  logic [DATA_W-1:0] rd1, rd2;
  logic d_wb, d_mr, d_mw, d_b, d_s;
  logic [3:0] d_cmd;
  assign cond = instruction[31:28];
  assign mode = instruction[27:26];
  assign i_bit = instruction[25];
  assign opcode = instruction[24:21];
  assign s_bit = instruction[20];
  assign rn = RA_W'(instruction[19:16]);
  assign rd = RA_W'(instruction[15:12]);
  assign rm = RA_W'(instruction[3:0]);
  assign {n, z, c, v} = status;
  assign str = mode == 2'b01 && !s_bit;
  assign src2 = str ? rd : rm;
  assign src1_used = !(mode == 2'b10 || (mode == 2'b00 && (opcode == 4'b1101 || opcode == 4'b1111)));
  assign src2_used = (mode == 2'b00 && !i_bit) || str;
`ifdef WB_BYPASS_EN
  assign rd1 = (wb_we && wb_dest == rn) ? wb_value : regs[rn];
  assign rd2 = (wb_we && wb_dest == src2) ? wb_value : regs[src2];
  function automatic logic busy(input logic [RA_W-1:0] a, input logic ew, input logic [RA_W-1:0] ed,
                                input logic mw, input logic [RA_W-1:0] md, input logic ww, input logic [RA_W-1:0] wd);
    return (ew && ed == a) || (mw && md == a);
  endfunction
`else
  assign rd1 = regs[rn];
  assign rd2 = regs[src2];
  function automatic logic busy(input logic [RA_W-1:0] a, input logic ew, input logic [RA_W-1:0] ed,
                                input logic mw, input logic [RA_W-1:0] md, input logic ww, input logic [RA_W-1:0] wd);
    return (ew && ed == a) || (mw && md == a) || (ww && wd == a);
  endfunction
`endif
  assign hazard = in_valid &&
    ((src1_used && busy(rn, exe_wb_en, exe_dest, mem_wb_en, mem_dest, wb_we, wb_dest)) ||
     (src2_used && busy(src2, exe_wb_en, exe_dest, mem_wb_en, mem_dest, wb_we, wb_dest)));
  assign advance = !out_valid || out_ready;
  assign in_ready = flush || (advance && !hazard);
  // ARM condition evaluation against the flags sampled this cycle
  always_comb begin
    case (cond)
      4'h0: cond_ok = z;
      4'h1: cond_ok = !z;
      4'h2: cond_ok = c;
      4'h3: cond_ok = !c;
      4'h4: cond_ok = n;
      4'h5: cond_ok = !n;
      4'h6: cond_ok = v;
      4'h7: cond_ok = !v;
      4'h8: cond_ok = c && !z;
      4'h9: cond_ok = !c || z;
      4'ha: cond_ok = n == v;
      4'hb: cond_ok = n != v;
      4'hc: cond_ok = !z && n == v;
      4'hd: cond_ok = z || n != v;
      4'he: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end
  // Control decode from mode/opcode/S
  always_comb begin
    d_wb = 1'b0;
    d_mr = 1'b0;
    d_mw = 1'b0;
    d_b = 1'b0;
    d_s = 1'b0;
    d_cmd = 4'b0000;
    case (mode)
      2'b00: begin
        d_s = s_bit;
        d_wb = 1'b1;
        case (opcode)
          4'b1101: d_cmd = 4'b0001;
          4'b1111: d_cmd = 4'b1001;
          4'b0100: d_cmd = 4'b0010;
          4'b0101: d_cmd = 4'b0011;
          4'b0010: d_cmd = 4'b0100;
          4'b0110: d_cmd = 4'b0101;
          4'b0000: d_cmd = 4'b0110;
          4'b1100: d_cmd = 4'b0111;
          4'b0001: d_cmd = 4'b1000;
          4'b1010: {d_cmd, d_wb, d_s} = {4'b0100, 1'b0, 1'b1};
          4'b1000: {d_cmd, d_wb, d_s} = {4'b0110, 1'b0, 1'b1};
          default: {d_wb, d_s} = 2'b00;
        endcase
      end
      2'b01: {d_cmd, d_wb, d_mr, d_mw} = {4'b0010, s_bit, s_bit, !s_bit};
      2'b10: d_b = 1'b1;
      default: d_b = 1'b0;
    endcase
  end
  // Register file write port; reset clears every entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**RA_W; i++) regs[i] <= '0;
    end else if (wb_we && 32'(wb_dest) < NREG) begin
      regs[wb_dest] <= wb_value;
    end
  end
  // ID/EX register: flush, hold, bubble, load or drain
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      {wb_en, mem_r_en, mem_w_en, b, s, exe_cmd} <= '0;
      imm <= 1'b0;
      shift_operand <= '0;
      signed_imm24 <= '0;
      dest <= '0;
      val_rn <= '0;
      val_rm <= '0;
      pc_out <= '0;
    end else if (flush || (advance && (hazard || !in_valid))) begin
      out_valid <= 1'b0;
      {wb_en, mem_r_en, mem_w_en, b, s, exe_cmd} <= '0;
    end else if (advance) begin
      out_valid <= 1'b1;
      {wb_en, mem_r_en, mem_w_en, b, s, exe_cmd} <= cond_ok ? {d_wb, d_mr, d_mw, d_b, d_s, d_cmd} : 9'd0;
      imm <= i_bit;
      shift_operand <= instruction[11:0];
      signed_imm24 <= instruction[23:0];
      dest <= rd;
      val_rn <= rd1;
      val_rm <= rd2;
      pc_out <= pc_in;
    end
  end
endmodule
